// File: rtl/dmem_bridge.sv
// Data-side memory bridge: byte-masked word RAM with optional wait states and a
// memory-mapped console TX FIFO, served over the core's mem_d_* strobe port.
module dmem_bridge #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned WAIT       = 0,
  parameter logic [31:0] CON_BASE   = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_d_addr,
  input  logic [31:0] mem_d_wdata,
  input  logic [3:0]  mem_d_wmask,
  input  logic        mem_d_wstrb,
  input  logic        mem_d_rstrb,
  output logic [31:0] mem_d_rdata,
  output logic        mem_d_rbusy,
  output logic        mem_d_wbusy,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);
  localparam int unsigned FAW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] WAIT_M1 = 4'(WAIT - 1);
  localparam logic [FAW:0] PTR_ONE = (FAW + 1)'(1);

  typedef enum logic [1:0] {IDLE, RWAIT, WWAIT, WFULL} state_e;

  logic [31:0] mem [2**ADDR_W];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [FAW:0]      wptr_q, wptr_d, rptr_q, rptr_d;

  logic              is_ram, is_con;
  logic [ADDR_W-1:0] addr_idx;
  logic [3:0]        con_off;
  logic              full, empty, pop, push;
  logic [7:0]        push_byte;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_widx;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_wmask;

  assign is_ram   = (mem_d_addr[31:ADDR_W+2] == '0);
  assign addr_idx = mem_d_addr[ADDR_W+1:2];
  assign is_con   = (mem_d_addr[31:4] == CON_BASE[31:4]);
  assign con_off  = mem_d_addr[3:0];

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FAW] != rptr_q[FAW]) && (wptr_q[FAW-1:0] == rptr_q[FAW-1:0]);
  assign pop   = con_ready && !empty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    idx_d     = idx_q;
    wdat_d    = wdat_q;
    wmask_d   = wmask_q;
    ram_we    = 1'b0;
    ram_widx  = idx_q;
    ram_wdata = wdat_q;
    ram_wmask = wmask_q;
    push      = 1'b0;
    push_byte = wdat_q[7:0];
    case (state_q)
      IDLE: begin
        // A store strobe wins over a coincident load strobe.
        if (mem_d_wstrb) begin
          if (is_ram) begin
            if (WAIT == 0) begin
              ram_we    = 1'b1;
              ram_widx  = addr_idx;
              ram_wdata = mem_d_wdata;
              ram_wmask = mem_d_wmask;
            end else begin
              idx_d   = addr_idx;
              wdat_d  = mem_d_wdata;
              wmask_d = mem_d_wmask;
              cnt_d   = WAIT_M1;
              state_d = WWAIT;
            end
          end else if (is_con && con_off == 4'h0 && mem_d_wmask[0]) begin
            if (!full || pop) begin
              push      = 1'b1;
              push_byte = mem_d_wdata[7:0];
            end else begin
              wdat_d  = mem_d_wdata;
              state_d = WFULL;
            end
          end
        end else if (mem_d_rstrb) begin
          if (is_ram) begin
            if (WAIT == 0) begin
              rdata_d = mem[addr_idx];
            end else begin
              idx_d   = addr_idx;
              cnt_d   = WAIT_M1;
              state_d = RWAIT;
            end
          end else if (is_con && con_off == 4'h4) begin
            rdata_d = {30'b0, full, empty};
          end else begin
            rdata_d = '0;
          end
        end
      end
      RWAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem[idx_q];
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WWAIT: begin
        if (cnt_q == '0) begin
          ram_we  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WFULL: begin
        if (!full || pop) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wptr_d = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_ONE : rptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      wdat_q  <= '0;
      wmask_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      wmask_q <= wmask_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage arrays are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (ram_wmask[i]) mem[ram_widx][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    if (push) fifo_mem[wptr_q[FAW-1:0]] <= push_byte;
  end

  assign mem_d_rdata = rdata_q;
  assign mem_d_rbusy = (state_q == RWAIT);
  assign mem_d_wbusy = (state_q == WWAIT) || (state_q == WFULL);
  assign con_valid   = !empty;
  assign con_data    = empty ? '0 : fifo_mem[rptr_q[FAW-1:0]];
endmodule
